// File: rtl/game_pkg.sv
// Shared types and constants for the maze game session controller:
// state encoding, difficulty selection and the bonus-box placement table.
package game_pkg;

  localparam int COORD_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_RESULT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DIFF_NONE,
    DIFF_EASY,
    DIFF_MED,
    DIFF_HARD
  } diff_e;

  typedef struct packed {
    logic [COORD_W-1:0] plus_x;
    logic [COORD_W-1:0] plus_y;
    logic [COORD_W-1:0] minus_x;
    logic [COORD_W-1:0] minus_y;
  } box_t;

  localparam box_t BOX_HARD = '{plus_x: 5'd10, plus_y: 5'd6, minus_x: 5'd15, minus_y: 5'd19};
  localparam box_t BOX_MED  = '{plus_x: 5'd17, plus_y: 5'd9, minus_x: 5'd4,  minus_y: 5'd6};
  localparam box_t BOX_EASY = '{plus_x: 5'd13, plus_y: 5'd5, minus_x: 5'd10, minus_y: 5'd3};

  // Exactly one switch high selects a difficulty; anything else is NONE.
  function automatic diff_e decode_sel(input logic h, input logic m, input logic e);
    case ({h, m, e})
      3'b100:  return DIFF_HARD;
      3'b010:  return DIFF_MED;
      3'b001:  return DIFF_EASY;
      default: return DIFF_NONE;
    endcase
  endfunction

  function automatic box_t box_of(input diff_e d);
    case (d)
      DIFF_HARD: return BOX_HARD;
      DIFF_MED:  return BOX_MED;
      DIFF_EASY: return BOX_EASY;
      default:   return '0;
    endcase
  endfunction

endpackage

// File: rtl/sat_score_acc.sv
// Saturating score accumulator: clear has priority, then add (clamps at
// all-ones), then subtract (floors at zero).
module sat_score_acc #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         clear,
  input  logic         add_en,
  input  logic         sub_en,
  input  logic [W-1:0] delta,
  output logic [W-1:0] acc
);

  logic [W:0]   sum;
  logic [W-1:0] acc_d;

  // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
  always_comb begin
    sum   = {1'b0, acc} + {1'b0, delta};
    acc_d = acc;
    if (clear)       acc_d = '0;
    else if (add_en) acc_d = sum[W] ? '1 : sum[W-1:0];
    else if (sub_en) acc_d = (delta > acc) ? '0 : acc - delta;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) acc <= '0;
    else         acc <= acc_d;
  end

endmodule

// File: rtl/game_session_ctrl.sv
// Maze game session sequencer: IDLE -> PLAY -> RESULT -> IDLE.
// Define GAME_TIME_BONUS_EN to add the remaining seconds to the score on a win.
module game_session_ctrl
  import game_pkg::*;
#(
  parameter int SCORE_W   = 8,
  parameter int TIMER_W   = 7,
  parameter int TIME_EASY = 60,
  parameter int TIME_MED  = 90,
  parameter int TIME_HARD = 120,
  parameter int BONUS     = 5
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               hard,
  input  logic               med,
  input  logic               easy,
  input  logic               start,
  input  logic               secTick,
  input  logic [COORD_W-1:0] playerX,
  input  logic [COORD_W-1:0] playerY,
  input  logic               atExit,
  output logic               playHard,
  output logic               playMedium,
  output logic               playEasy,
  output logic               externalReset,
  output logic [COORD_W-1:0] scorePlusFiveX,
  output logic [COORD_W-1:0] scorePlusFiveY,
  output logic [COORD_W-1:0] scoreMinusFiveX,
  output logic [COORD_W-1:0] scoreMinusFiveY,
  output logic               plusTaken,
  output logic               minusTaken,
  output logic [SCORE_W-1:0] score,
  output logic [TIMER_W-1:0] timeLeft,
  output logic               won,
  output logic               lost,
  output logic [1:0]         state
);

  state_e             st;
  diff_e              sel;
  box_t               box;
  logic               sw_off, on_plus, on_minus, play_live, win_evt, to_idle;
  logic               acc_clr, acc_add, acc_sub;
  logic [SCORE_W-1:0] acc_delta;

  function automatic logic [TIMER_W-1:0] start_time(input diff_e d);
    case (d)
      DIFF_HARD: return TIMER_W'(TIME_HARD);
      DIFF_MED:  return TIMER_W'(TIME_MED);
      DIFF_EASY: return TIMER_W'(TIME_EASY);
      default:   return '0;
    endcase
  endfunction

  assign sel      = decode_sel(hard, med, easy);
  assign sw_off   = !(hard || med || easy);
  assign on_plus  = (playerX == box.plus_x)  && (playerY == box.plus_y);
  assign on_minus = (playerX == box.minus_x) && (playerY == box.minus_y);

  // Abort beats exit, exit beats timeout, timeout beats bonus collection.
  assign win_evt   = (st == ST_PLAY) && !sw_off && atExit;
  assign play_live = (st == ST_PLAY) && !sw_off && !atExit && (timeLeft != '0);
  assign to_idle   = ((st == ST_PLAY) && sw_off) || ((st == ST_RESULT) && (start || sw_off));

  assign acc_clr = (st == ST_IDLE) && start && (sel != DIFF_NONE);
  assign acc_sub = play_live && on_minus && !minusTaken;
`ifdef GAME_TIME_BONUS_EN
  assign acc_add   = (play_live && on_plus && !plusTaken) || win_evt;
  assign acc_delta = win_evt ? SCORE_W'(timeLeft) : SCORE_W'(BONUS);
`else
  assign acc_add   = play_live && on_plus && !plusTaken;
  assign acc_delta = SCORE_W'(BONUS);
`endif

  sat_score_acc #(.W(SCORE_W)) u_score (
    .clock  (clock),
    .resetn (resetn),
    .clear  (acc_clr),
    .add_en (acc_add),
    .sub_en (acc_sub),
    .delta  (acc_delta),
    .acc    (score)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      st            <= ST_IDLE;
      externalReset <= 1'b1;
      {playHard, playMedium, playEasy} <= '0;
      box           <= '0;
      plusTaken     <= 1'b0;
      minusTaken    <= 1'b0;
      timeLeft      <= '0;
      won           <= 1'b0;
      lost          <= 1'b0;
    end else if (to_idle) begin
      // Score and time stay on the HUD after returning to the menu.
      st            <= ST_IDLE;
      externalReset <= 1'b1;
      {playHard, playMedium, playEasy} <= '0;
      box           <= '0;
      plusTaken     <= 1'b0;
      minusTaken    <= 1'b0;
      won           <= 1'b0;
      lost          <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (start && sel != DIFF_NONE) begin
            st            <= ST_PLAY;
            externalReset <= 1'b0;
            playHard      <= (sel == DIFF_HARD);
            playMedium    <= (sel == DIFF_MED);
            playEasy      <= (sel == DIFF_EASY);
            box           <= box_of(sel);
            timeLeft      <= start_time(sel);
            plusTaken     <= 1'b0;
            minusTaken    <= 1'b0;
            won           <= 1'b0;
            lost          <= 1'b0;
          end
        end
        ST_PLAY: begin
          if (atExit) begin
            won <= 1'b1;
            st  <= ST_RESULT;
          end else if (timeLeft == '0) begin
            lost <= 1'b1;
            st   <= ST_RESULT;
          end else begin
            if (on_plus)  plusTaken  <= 1'b1;
            if (on_minus) minusTaken <= 1'b1;
            if (secTick)  timeLeft   <= timeLeft - 1'b1;
          end
        end
        ST_RESULT: ;
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign state           = st;
  assign scorePlusFiveX  = box.plus_x;
  assign scorePlusFiveY  = box.plus_y;
  assign scoreMinusFiveX = box.minus_x;
  assign scoreMinusFiveY = box.minus_y;

endmodule
